// File: rtl/led_hunt_game.sv
// LED hunt minigame: the operator must name the lit LED index ROUNDS times in a row.
// All outputs are registered; the mode FSM decodes random_led and blanks LEDs on game_led_off.
module led_hunt_game #(
  parameter int unsigned CLK_PER_TICK = 50_000_000,
  parameter int unsigned GAP_TICKS    = 1,
  parameter int unsigned ROUNDS       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_game,
  input  logic       btnC,
  input  logic [3:0] guess,
  output logic [3:0] random_led,
  output logic       game_led_off,
  output logic       game_done,
  output logic [3:0] streak
);

  localparam int unsigned CycW  = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int unsigned TickW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [CycW-1:0]  CycLast  = CycW'(CLK_PER_TICK - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(GAP_TICKS - 1);
  localparam logic [CycW-1:0]  CycOne   = CycW'(1);
  localparam logic [TickW-1:0] TickOne  = TickW'(1);
  localparam logic [3:0]       RoundsL  = 4'(ROUNDS);
  localparam logic [15:0]      LfsrSeed = 16'hACE1;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StGap,
    StDone
  } state_e;

  state_e           state_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic             btn_q;
  logic [3:0]       prev_q;
  logic [CycW-1:0]  cyc_q;
  logic [TickW-1:0] tick_q;
  logic [3:0]       random_led_q;
  logic [3:0]       streak_q;
  logic             led_off_q;
  logic             done_q;

  logic             press;
  logic             hit;
  logic             last_round;
  logic             gap_end;
  logic [3:0]       raw_t;
  logic [3:0]       draw_t;
  logic [3:0]       streak_inc;

  // Target draw: fold 15 onto 0, then bump past the previous target so it never repeats.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    raw_t  = (lfsr_q[3:0] == 4'd15) ? 4'd0 : lfsr_q[3:0];
    draw_t = raw_t;
    if (raw_t == prev_q) begin
      draw_t = (raw_t == 4'd14) ? 4'd0 : raw_t + 4'd1;
    end
  end

  // btn_q tracks btnC in every state, so a press held over from before SHOW never submits.
  assign press      = btnC & ~btn_q;
  assign hit        = (guess == random_led_q) && (guess != 4'd15);
  assign streak_inc = streak_q + 4'd1;
  assign last_round = (streak_inc == RoundsL);
  assign gap_end    = (cyc_q == CycLast) && (tick_q == TickLast);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      lfsr_q       <= LfsrSeed;
      btn_q        <= 1'b0;
      prev_q       <= 4'd0;
      cyc_q        <= '0;
      tick_q       <= '0;
      random_led_q <= 4'd0;
      streak_q     <= 4'd0;
      led_off_q    <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      btn_q  <= btnC;
      done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          random_led_q <= 4'd0;
          led_off_q    <= 1'b1;
          if (enable_game) begin
            state_q      <= StShow;
            random_led_q <= draw_t;
            prev_q       <= draw_t;
            streak_q     <= 4'd0;
            led_off_q    <= 1'b0;
          end
        end

        StShow: begin
          if (!enable_game) begin
            state_q      <= StIdle;
            random_led_q <= 4'd0;
            led_off_q    <= 1'b1;
          end else if (press) begin
            led_off_q <= 1'b1;
            cyc_q     <= '0;
            tick_q    <= '0;
            if (hit && last_round) begin
              state_q  <= StDone;
              streak_q <= RoundsL;
              done_q   <= 1'b1;
            end else begin
              state_q      <= StGap;
              streak_q     <= hit ? streak_inc : 4'd0;
              random_led_q <= draw_t;
              prev_q       <= draw_t;
            end
          end
        end

        StGap: begin
          if (!enable_game) begin
            state_q      <= StIdle;
            random_led_q <= 4'd0;
            led_off_q    <= 1'b1;
            cyc_q        <= '0;
            tick_q       <= '0;
          end else if (gap_end) begin
            state_q   <= StShow;
            led_off_q <= 1'b0;
            cyc_q     <= '0;
            tick_q    <= '0;
          end else if (cyc_q == CycLast) begin
            cyc_q  <= '0;
            tick_q <= tick_q + TickOne;
          end else begin
            cyc_q <= cyc_q + CycOne;
          end
        end

        StDone: begin
          state_q      <= StIdle;
          random_led_q <= 4'd0;
          led_off_q    <= 1'b1;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign random_led   = random_led_q;
  assign game_led_off = led_off_q;
  assign game_done    = done_q;
  assign streak       = streak_q;

endmodule

// File: tb/tb_led_hunt_game.sv
// Directed bench for led_hunt_game with a small reference LFSR to predict each drawn target.
module tb_led_hunt_game;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_game;
  logic       btnC;
  logic [3:0] guess;
  logic [3:0] random_led;
  logic       game_led_off;
  logic       game_done;
  logic [3:0] streak;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;

  logic [15:0] lfsr_m;
  logic [3:0]  exp_led;
  logic [3:0]  exp_streak;
  logic [3:0]  prev_m;
  logic [3:0]  want;

  led_hunt_game #(
    .CLK_PER_TICK(4),
    .GAP_TICKS   (2),
    .ROUNDS      (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_game (enable_game),
    .btnC        (btnC),
    .guess       (guess),
    .random_led  (random_led),
    .game_led_off(game_led_off),
    .game_done   (game_done),
    .streak      (streak)
  );

  always #5 clk = ~clk;

  // Reference LFSR (taps 16,14,13,11) and a count of cycles with game_done high.
  always @(posedge clk) begin
    if (!reset) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    if (game_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [3:0] draw_f(input logic [3:0] raw, input logic [3:0] prev);
    logic [3:0] t;
    t = (raw == 4'd15) ? 4'd0 : raw;
    if (t == prev) t = (t == 4'd14) ? 4'd0 : t + 4'd1;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_off"}, {15'd0, game_led_off}, 16'd1);
    check({tag, "_led"}, {12'd0, random_led}, 16'd0);
    check({tag, "_done"}, {15'd0, game_done}, 16'd0);
  endtask

  task automatic start_game();
    enable_game = 1'b1;
    exp_led     = draw_f(lfsr_m[3:0], prev_m);
    prev_m      = exp_led;
    exp_streak  = 4'd0;
    step();
    check("start_off", {15'd0, game_led_off}, 16'd0);
    check("start_led", {12'd0, random_led}, {12'd0, exp_led});
    check("start_streak", {12'd0, streak}, 16'd0);
  endtask

  task automatic submit(input logic [3:0] g);
    guess = g;
    btnC  = 1'b1;
    if (g == exp_led && g != 4'd15) exp_streak = exp_streak + 4'd1;
    else                            exp_streak = 4'd0;
    if (exp_streak != 4'd3) begin
      exp_led = draw_f(lfsr_m[3:0], prev_m);
      prev_m  = exp_led;
    end
    step();
    btnC = 1'b0;
    check("sub_streak", {12'd0, streak}, {12'd0, exp_streak});
    check("sub_off", {15'd0, game_led_off}, 16'd1);
    if (exp_streak == 4'd3) begin
      check("sub_done", {15'd0, game_done}, 16'd1);
    end else begin
      check("sub_done", {15'd0, game_done}, 16'd0);
      check("sub_next_led", {12'd0, random_led}, {12'd0, exp_led});
    end
  endtask

  task automatic gap();
    int n;
    n = 0;
    while (game_led_off === 1'b1 && n < 20) begin
      n++;
      step();
    end
    check("gap_len", 16'(n), 16'd8);
    check("gap_show_led", {12'd0, random_led}, {12'd0, exp_led});
  endtask

  task automatic wait_raw(input logic [3:0] r);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (lfsr_m[3:0] == r) ok = 1'b1;
      else                  step();
    end
    check("wait_raw", {15'd0, ok}, 16'd1);
  endtask

  initial begin
    reset       = 1'b0;
    enable_game = 1'b0;
    btnC        = 1'b0;
    guess       = 4'd0;
    prev_m      = 4'd0;
    exp_led     = 4'd0;
    exp_streak  = 4'd0;
    @(negedge clk);
    step();

    // 1: reset state, then start with btnC already held
    check_idle("rst");
    check("rst_streak", {12'd0, streak}, 16'd0);
    check("rst_lfsr", dut.lfsr_q, 16'hACE1);
    reset = 1'b1;
    btnC  = 1'b1;
    step();
    start_game();
    check("not15", {15'd0, random_led != 4'd15}, 16'd1);
    guess = exp_led;
    step();
    step();
    check("held_streak", {12'd0, streak}, 16'd0);
    check("held_off", {15'd0, game_led_off}, 16'd0);
    btnC = 1'b0;
    step();

    // 2: three correct in a row wins
    submit(exp_led);
    gap();
    submit(exp_led);
    gap();
    submit(exp_led);
    enable_game = 1'b0;
    step();
    check_idle("won");
    check("won_streak", {12'd0, streak}, 16'd3);
    step();
    check_idle("won2");
    check("won2_streak", {12'd0, streak}, 16'd3);

    // 3: correct, correct, wrong -> streak resets, game continues
    start_game();
    submit(exp_led);
    gap();
    submit(exp_led);
    gap();
    submit(4'd15);
    gap();

    // 4: forced collisions on the draw
    wait_raw(exp_led);
    want = (exp_led == 4'd14) ? 4'd0 : exp_led + 4'd1;
    submit(exp_led);
    check("collide", {12'd0, random_led}, {12'd0, want});
    gap();
    want = (prev_m == 4'd0) ? 4'd1 : 4'd0;
    wait_raw(4'd15);
    submit(4'd15);
    check("raw15", {12'd0, random_led}, {12'd0, want});
    gap();
    if (prev_m != 4'd14) begin
      wait_raw(4'd14);
      submit(4'd15);
      check("got14", {12'd0, random_led}, 16'd14);
      gap();
    end
    wait_raw(4'd14);
    submit(4'd15);
    check("wrap14", {12'd0, random_led}, 16'd0);
    gap();

    // 5: abort mid-gap
    submit(4'd15);
    step();
    step();
    enable_game = 1'b0;
    step();
    check_idle("abort");
    step();
    step();
    check_idle("abort2");
    check("done_count", 16'(done_cnt), 16'd1);

    // 6: reset in SHOW with streak 2
    start_game();
    submit(exp_led);
    gap();
    submit(exp_led);
    gap();
    check("pre_rst_streak", {12'd0, streak}, 16'd2);
    reset       = 1'b0;
    enable_game = 1'b0;
    step();
    check_idle("mid_rst");
    check("mid_rst_streak", {12'd0, streak}, 16'd0);
    check("mid_rst_lfsr", dut.lfsr_q, 16'hACE1);
    reset  = 1'b1;
    prev_m = 4'd0;
    step();
    check("done_after_rst", 16'(done_cnt), 16'd1);
    start_game();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_hunt_game.md
# led_hunt_game

- Alarm-dismiss minigame, driven by the top-level mode FSM while it is in its Game state.
- Consumes `enable_game`, the operator's 4-bit guess and `btnC`.
- Produces the signals the FSM expects from it:
  - `random_led`: target index, which the FSM one-hot decodes onto led[14:0].
  - `game_led_off`: LED blank between rounds.
  - `game_done`: finish pulse that releases the FSM from Game.
- The operator must identify the lit LED index ROUNDS times in a row. A wrong guess resets the streak.

## Interface

Parameters:

- CLK_PER_TICK, 50_000_000: clock cycles per gap tick.
- GAP_TICKS, 1: ticks of blank LEDs between rounds.
- ROUNDS, 3: consecutive correct guesses needed to finish (1..15).

Ports:

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  reset; one clock, synchronous, active-low.
- enable_game  in  1  level; high while the FSM is in Game.
- btnC  in  1  submit button, debounced level; rising edge = submit.
- guess  in  4  operator's guessed LED index (0..14).
- random_led  out  4  current target index 0..14; 0 when idle.
- game_led_off  out  1  1 = FSM must blank led[14:0].
- game_done  out  1  one-cycle pulse: game won.
- streak  out  4  consecutive correct guesses in the current game.

## Operation

Reset (reset low at a rising edge):

- state=IDLE, random_led=0, game_led_off=1, game_done=0, streak=0.
- btn_q=0, prev_target=0, tick counters=0, LFSR=16'hACE1.

LFSR:

- 16-bit Fibonacci LFSR, taps 16,14,13,11.
- Shifts every cycle outside reset, independent of state.

Target draw:

- raw = lfsr[3:0]; t = (raw==15) ? 0 : raw.
- If t == prev_target then t = (t==14) ? 0 : t+1.
- The drawn t is loaded into random_led and prev_target.

Submit detect:

- press = btnC & ~btn_q.
- btn_q updates every cycle in every state.
- Consequence: a button still held from the bell-dismiss press never counts as a submit.

States:

- IDLE:
  - Outputs: game_led_off=1, random_led=0.
  - enable_game=1 → draw target, streak=0, go SHOW.
- SHOW:
  - Outputs: game_led_off=0, random_led=target.
  - enable_game=0 → IDLE (abort, no game_done).
  - press with guess==random_led and streak+1==ROUNDS → streak=ROUNDS, go DONE.
  - press with guess==random_led otherwise → streak+1, draw new target, go GAP.
  - press with guess!=random_led → streak=0, draw new target, go GAP.
  - No press → stay.
- GAP:
  - Outputs: game_led_off=1, random_led holds the already-drawn next target.
  - Tick counters clear on entry.
  - After GAP_TICKS*CLK_PER_TICK cycles → SHOW.
  - enable_game=0 → IDLE.
  - Presses are ignored.
- DONE:
  - Outputs: game_done=1, game_led_off=1.
  - Unconditionally → IDLE next cycle.

IDLE side effects:

- streak keeps its last value until the next game start, so the display can show the final score.
- random_led is forced to 0.

Boundary rules:

- A guess of 15 is always wrong.
- The abort check has priority over press in SHOW.
- ROUNDS=1 → the first correct guess goes straight to DONE.

## Timing

- enable_game rises at edge N (IDLE) → SHOW and a valid random_led from edge N+1.
- A press sampled at edge M in SHOW → streak, random_led and state update at edge M+1; game_led_off=1 from M+1.
- GAP duration: exactly GAP_TICKS*CLK_PER_TICK cycles, then game_led_off=0 on the next cycle.
- game_done is high exactly one cycle. The FSM drops enable_game in response; the block is already in IDLE the cycle after.
- enable_game low in SHOW/GAP at edge K → IDLE outputs from K+1.
- Reset mid-game: all outputs return to their reset values at that edge. No game_done.

## Test plan

Use CLK_PER_TICK=4, GAP_TICKS=2, ROUNDS=3 throughout.

1. Reset, then enable_game=1 with btnC held high → SHOW, game_led_off=0, random_led≠15; no submit registered until btnC is released and pressed again.
2. Three correct submits (guess=random_led, edges spaced after each gap) → streak 1,2,3; each gap has game_led_off=1 for exactly 8 cycles; game_done single-cycle pulse after the third; state IDLE; streak=3.
3. Correct, correct, wrong (guess=15) → streak 1,2,0; no game_done; game continues in SHOW after an 8-cycle gap.
4. Consecutive targets never repeat: force the LFSR so that raw equals prev_target → new target = prev_target+1 (14 wraps to 0); raw=15 maps to 0.
5. enable_game dropped mid-GAP → IDLE next cycle, random_led=0, game_led_off=1, game_done never asserted.
6. Reset asserted in SHOW with streak=2 → next cycle all outputs at reset values, LFSR=16'hACE1.
